// File: rtl/bitwise_logic_unit_pkg.sv
// ---------------------------------------------------------------------------
// minicpu_alu_pkg
// Shared definitions for the MiniCPU logic/ALU datapath: the 3-bit logic
// operation codes and the state encoding of the slice-serial logic unit.
// The op codes are also meant for the future ALU op decoder, so keep the
// encodings stable.
// ---------------------------------------------------------------------------
package minicpu_alu_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_AND  = 3'b000;
    localparam op_t OP_OR   = 3'b001;
    localparam op_t OP_XOR  = 3'b010;
    localparam op_t OP_NAND = 3'b011;
    localparam op_t OP_NOR  = 3'b100;
    localparam op_t OP_XNOR = 3'b101;
    localparam op_t OP_NOTA = 3'b110;
    localparam op_t OP_ANDN = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/bitwise_logic_unit_if.sv
// ---------------------------------------------------------------------------
// bitwise_logic_unit_if
// Request/response bundle of the bitwise logic unit.
//   Request  : in_valid, in_ready, op, a, b
//   Response : out_valid, out_ready, result, zero, parity
// master = requester/consumer side, slave = the logic unit itself.
// ---------------------------------------------------------------------------
interface bitwise_logic_unit_if
    import minicpu_alu_pkg::*;
#(
    parameter int WIDTH = 8
);

    logic             in_valid;
    logic             in_ready;
    op_t              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             parity;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero, parity
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero, parity
    );

endinterface

// File: rtl/bitwise_logic_unit_slice.sv
// ---------------------------------------------------------------------------
// logic_slice
// Purely combinational SLICE-bit logic cell used by the slice-serial unit.
//   op      : operation code (minicpu_alu_pkg OP_*)
//   a_s,b_s : operand slices
//   y_s     : operation result for this slice
//   y_zero  : 1 when y_s is all zeros
//   y_par   : XOR reduction of y_s
// ---------------------------------------------------------------------------
module logic_slice
    import minicpu_alu_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  op_t              op,
    input  logic [SLICE-1:0] a_s,
    input  logic [SLICE-1:0] b_s,
    output logic [SLICE-1:0] y_s,
    output logic             y_zero,
    output logic             y_par
);

    // Every op code is defined; NOT A simply ignores b_s.
    always_comb begin
        y_s = '0;
        case (op)
            OP_AND:  y_s = a_s & b_s;
            OP_OR:   y_s = a_s | b_s;
            OP_XOR:  y_s = a_s ^ b_s;
            OP_NAND: y_s = ~(a_s & b_s);
            OP_NOR:  y_s = ~(a_s | b_s);
            OP_XNOR: y_s = ~(a_s ^ b_s);
            OP_NOTA: y_s = ~a_s;
            OP_ANDN: y_s = a_s & ~b_s;
        endcase
    end

    assign y_zero = (y_s == '0);
    assign y_par  = ^y_s;

endmodule

// File: rtl/bitwise_logic_unit.sv
// ---------------------------------------------------------------------------
// bitwise_logic_unit
// Slice-serial bitwise logic unit: latches one operand pair, then produces
// SLICE result bits per cycle (LSB slice first) and finally presents the
// full result with zero and parity flags.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : bitwise_logic_unit_if slave port (request + response handshake)
// ---------------------------------------------------------------------------
module bitwise_logic_unit
    import minicpu_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    bitwise_logic_unit_if.slave  bus
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    // Refuse to build a unit whose width does not split into whole slices.
    generate
        if ((SLICE < 1) || (WIDTH < SLICE) || ((WIDTH % SLICE) != 0)) begin : g_badParams
            $error("bitwise_logic_unit: WIDTH must be a non-zero multiple of SLICE");
        end
    endgenerate

    state_t                  r_state;
    state_t                  w_nextState;
    logic [CW-1:0]           r_cnt;
    op_t                     r_op;
    logic [N-1:0][SLICE-1:0] r_a;
    logic [N-1:0][SLICE-1:0] r_b;
    logic [N-1:0][SLICE-1:0] r_result;
    logic                    r_accZero;
    logic                    r_accPar;
    logic                    r_zero;
    logic                    r_parity;
    logic                    r_outValid;

    logic                    w_accept;
    logic                    w_lastSlice;
    logic                    w_release;
    logic [SLICE-1:0]        w_ySlice;
    logic                    w_yZero;
    logic                    w_yPar;

    // A single slice cell, fed by the counter-selected slice of the latched operands.
    logic_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .op     (r_op),
        .a_s    (r_a[r_cnt]),
        .b_s    (r_b[r_cnt]),
        .y_s    (w_ySlice),
        .y_zero (w_yZero),
        .y_par  (w_yPar)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode plus the three strobes that steer the datapath:
    // accept a request, write the final slice, hand the result over.
    // Acceptance is blocked while rst is high so a request can never slip
    // in during the reset cycle.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        w_lastSlice = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid && !rst) begin
                    w_accept    = 1'b1;
                    w_nextState = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (r_cnt == LAST) begin
                    w_lastSlice = 1'b1;
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    w_release   = 1'b1;
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Operand/op capture at acceptance; afterwards the bus inputs may change
    // freely. No reset needed: these are always reloaded before use.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op <= bus.op;
            r_a  <= bus.a;
            r_b  <= bus.b;
        end
    end

    // Slice counter, result register and flag accumulators. The zero
    // accumulator starts at 1 (nothing non-zero seen yet) and the parity
    // accumulator at 0; the final slice's contribution is folded in directly
    // when loading the visible flags so they appear together with out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_result   <= '0;
            r_accZero  <= 1'b0;
            r_accPar   <= 1'b0;
            r_zero     <= 1'b0;
            r_parity   <= 1'b0;
            r_outValid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt     <= '0;
                r_accZero <= 1'b1;
                r_accPar  <= 1'b0;
            end
            if (r_state == ST_BUSY) begin
                r_result[r_cnt] <= w_ySlice;
                r_accZero       <= r_accZero & w_yZero;
                r_accPar        <= r_accPar ^ w_yPar;
                if (w_lastSlice) begin
                    r_zero     <= r_accZero & w_yZero;
                    r_parity   <= r_accPar ^ w_yPar;
                    r_outValid <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if (w_release) begin
                r_outValid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE) && !rst;
    assign bus.out_valid = r_outValid;
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.parity    = r_parity;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// ---------------------------------------------------------------------------
// tb_bitwise_logic_unit
// Drives three unit configurations (8/4, 16/4, 8/8) one at a time through a
// shared set of driver variables; 'sel' chooses which instance sees the
// handshake. Expected values come from a whole-word reference function.
// ---------------------------------------------------------------------------
module tb_bitwise_logic_unit;
    import minicpu_alu_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    int          sel;
    logic        drvValid;
    logic        drvOutReady;
    logic [2:0]  drvOp;
    logic [15:0] drvA;
    logic [15:0] drvB;

    logic        mInReady;
    logic        mOutValid;
    logic        mZero;
    logic        mParity;
    logic [15:0] mResult;

    int totalChecks = 0;
    int badChecks   = 0;

    int widthOf [3] = '{8, 16, 8};
    int sliceOf [3] = '{4, 4, 8};

    bit          injectPending;
    logic [2:0]  injOp;
    logic [15:0] injA;
    logic [15:0] injB;

    bitwise_logic_unit_if #(.WIDTH(8))  bus8x4  ();
    bitwise_logic_unit_if #(.WIDTH(16)) bus16x4 ();
    bitwise_logic_unit_if #(.WIDTH(8))  bus8x8  ();

    bitwise_logic_unit #(.WIDTH(8), .SLICE(4)) dut8x4 (
        .clk (clk), .rst (rst), .bus (bus8x4)
    );
    bitwise_logic_unit #(.WIDTH(16), .SLICE(4)) dut16x4 (
        .clk (clk), .rst (rst), .bus (bus16x4)
    );
    bitwise_logic_unit #(.WIDTH(8), .SLICE(8)) dut8x8 (
        .clk (clk), .rst (rst), .bus (bus8x8)
    );

    assign bus8x4.in_valid   = drvValid && (sel == 0);
    assign bus8x4.op         = drvOp;
    assign bus8x4.a          = drvA[7:0];
    assign bus8x4.b          = drvB[7:0];
    assign bus8x4.out_ready  = drvOutReady && (sel == 0);

    assign bus16x4.in_valid  = drvValid && (sel == 1);
    assign bus16x4.op        = drvOp;
    assign bus16x4.a         = drvA;
    assign bus16x4.b         = drvB;
    assign bus16x4.out_ready = drvOutReady && (sel == 1);

    assign bus8x8.in_valid   = drvValid && (sel == 2);
    assign bus8x8.op         = drvOp;
    assign bus8x8.a          = drvA[7:0];
    assign bus8x8.b          = drvB[7:0];
    assign bus8x8.out_ready  = drvOutReady && (sel == 2);

    // Route the selected instance's outputs to one set of monitor signals.
    always_comb begin
        mInReady  = bus8x4.in_ready;
        mOutValid = bus8x4.out_valid;
        mResult   = {8'h00, bus8x4.result};
        mZero     = bus8x4.zero;
        mParity   = bus8x4.parity;
        if (sel == 1) begin
            mInReady  = bus16x4.in_ready;
            mOutValid = bus16x4.out_valid;
            mResult   = bus16x4.result;
            mZero     = bus16x4.zero;
            mParity   = bus16x4.parity;
        end else if (sel == 2) begin
            mInReady  = bus8x8.in_ready;
            mOutValid = bus8x8.out_valid;
            mResult   = {8'h00, bus8x8.result};
            mZero     = bus8x8.zero;
            mParity   = bus8x8.parity;
        end
    end

    // Whole-word reference: the operation applied to the full operands,
    // trimmed to the configured width.
    function automatic logic [15:0] refResult(input logic [2:0] op, input logic [15:0] a,
                                              input logic [15:0] b, input int w);
        logic [15:0] r;
        logic [15:0] mask;
        case (op)
            3'd0:    r = a & b;
            3'd1:    r = a | b;
            3'd2:    r = a ^ b;
            3'd3:    r = ~(a & b);
            3'd4:    r = ~(a | b);
            3'd5:    r = ~(a ^ b);
            3'd6:    r = ~a;
            default: r = a & ~b;
        endcase
        mask = 16'((32'h1 << w) - 32'h1);
        return r & mask;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got=%0h expected=%0h (cfg %0d)", tag, got, exp, sel);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction on the selected instance. 'hold' is the number
    // of cycles out_ready stays low once the result is presented.
    task automatic applyStimulus(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input int hold, input string tag);
        logic [15:0] expRes;
        logic        expZero;
        logic        expPar;
        int          n;
        int          cyc;
        n       = widthOf[sel] / sliceOf[sel];
        expRes  = refResult(op, a, b, widthOf[sel]);
        expZero = (expRes == 16'h0);
        expPar  = ^expRes;

        drvOp       = op;
        drvA        = a;
        drvB        = b;
        drvValid    = 1'b1;
        drvOutReady = (hold == 0);
        cyc = 0;
        while (!mInReady && cyc < 50) begin
            tick();
            cyc++;
        end
        if (!mInReady) begin
            checkOutput({tag, " accept timeout"}, 32'(mInReady), 32'd1);
            drvValid = 1'b0;
            return;
        end
        tick();
        drvValid = 1'b0;
        drvOp    = 3'($urandom);
        drvA     = 16'($urandom);
        drvB     = 16'($urandom);
        checkOutput({tag, " in_ready busy"}, 32'(mInReady), 32'd0);

        cyc = 0;
        while (!mOutValid && cyc < 50) begin
            tick();
            cyc++;
        end
        checkOutput({tag, " latency"}, 32'(cyc), 32'(n));
        checkOutput({tag, " result"}, 32'(mResult), 32'(expRes));
        checkOutput({tag, " zero"}, 32'(mZero), 32'(expZero));
        checkOutput({tag, " parity"}, 32'(mParity), 32'(expPar));

        for (int i = 0; i < hold; i++) begin
            if (injectPending) begin
                drvValid = 1'b1;
                drvOp    = injOp;
                drvA     = injA;
                drvB     = injB;
            end
            tick();
            checkOutput({tag, " hold out_valid"}, 32'(mOutValid), 32'd1);
            checkOutput({tag, " hold result"}, 32'(mResult), 32'(expRes));
            checkOutput({tag, " hold flags"}, {30'd0, mZero, mParity}, {30'd0, expZero, expPar});
            checkOutput({tag, " hold in_ready"}, 32'(mInReady), 32'd0);
        end
        injectPending = 1'b0;
        drvOutReady   = 1'b1;
        tick();
        checkOutput({tag, " released"}, {31'd0, mOutValid}, 32'd0);
        checkOutput({tag, " in_ready back"}, 32'(mInReady), 32'd1);
    endtask

    // Hard stop in case something below loses track of time.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    logic [15:0] sweepExp [8] = '{16'h18, 16'h5A, 16'h42, 16'hE7, 16'hA5, 16'hBD, 16'hA5, 16'h42};

    initial begin
        int seen;
        sel           = 0;
        rst           = 1'b1;
        drvValid      = 1'b0;
        drvOutReady   = 1'b0;
        drvOp         = 3'd0;
        drvA          = 16'h0;
        drvB          = 16'h0;
        injectPending = 1'b0;
        injOp         = 3'd0;
        injA          = 16'h0;
        injB          = 16'h0;

        repeat (3) tick();
        checkOutput("reset out_valid", 32'(mOutValid), 32'd0);
        checkOutput("reset result", 32'(mResult), 32'd0);
        checkOutput("reset flags", {30'd0, mZero, mParity}, 32'd0);
        checkOutput("reset in_ready low", 32'(mInReady), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("in_ready after reset", 32'(mInReady), 32'd1);

        applyStimulus(3'd0, 16'h00A5, 16'h000F, 0, "and A5 0F");
        checkOutput("and A5 0F value", 32'(refResult(3'd0, 16'h00A5, 16'h000F, 8)), 32'h05);

        for (int op = 0; op < 8; op++) begin
            applyStimulus(3'(op), 16'h005A, 16'h0018, 0, $sformatf("sweep op%0d", op));
            checkOutput($sformatf("sweep op%0d table", op), 32'(mResult), 32'(sweepExp[op]));
        end

        applyStimulus(3'd3, 16'h00FF, 16'h00FF, 0, "nand FF FF");
        applyStimulus(3'd4, 16'h0000, 16'h0001, 0, "nor 00 01");
        checkOutput("nor 00 01 held result", 32'(mResult), 32'hFE);
        checkOutput("nor 00 01 held parity", 32'(mParity), 32'd1);

        injectPending = 1'b1;
        injOp         = 3'd2;
        injA          = 16'h00C3;
        injB          = 16'h0081;
        applyStimulus(3'd1, 16'h0012, 16'h0040, 5, "backpressure");
        applyStimulus(injOp, injA, injB, 0, "queued request");

        applyStimulus(3'd4, 16'h0000, 16'h0001, 0, "pre-abort");
        drvOp       = 3'd1;
        drvA        = 16'h00F0;
        drvB        = 16'h000F;
        drvValid    = 1'b1;
        drvOutReady = 1'b1;
        tick();
        drvValid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        checkOutput("abort out_valid", 32'(mOutValid), 32'd0);
        checkOutput("abort result", 32'(mResult), 32'd0);
        checkOutput("abort flags", {30'd0, mZero, mParity}, 32'd0);
        checkOutput("abort in_ready in reset", 32'(mInReady), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("abort in_ready after", 32'(mInReady), 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (mOutValid) seen++;
        end
        checkOutput("abort no out_valid", 32'(seen), 32'd0);

        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            for (int op = 0; op < 8; op++) begin
                applyStimulus(3'(op), 16'h5A3C, 16'h18F0, 0, $sformatf("cfg sweep op%0d", op));
            end
            for (int i = 0; i < 20; i++) begin
                applyStimulus(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                              $urandom_range(0, 2), $sformatf("random %0d", i));
            end
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
